// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage request and EX-select/stall response bundle of the hazard and forwarding controller.
interface fwd_hazard_ctrl_if #(
    parameter int REG_ADDR_LEN = 4,
    parameter int CNT_LEN      = 16
);
    logic                    i_id_valid;
    logic [REG_ADDR_LEN-1:0] i_id_src1;
    logic [REG_ADDR_LEN-1:0] i_id_src2;
    logic                    i_id_two_src;
    logic [REG_ADDR_LEN-1:0] i_id_dest;
    logic                    i_id_wb_en;
    logic                    i_id_mem_read;
    logic                    i_branch_taken;
    logic                    o_stall;
    logic [1:0]              o_sel_src1;
    logic [1:0]              o_sel_src2;
    logic [CNT_LEN-1:0]      o_stall_cnt;

    modport slave (
        input  i_id_valid, i_id_src1, i_id_src2, i_id_two_src, i_id_dest,
               i_id_wb_en, i_id_mem_read, i_branch_taken,
        output o_stall, o_sel_src1, o_sel_src2, o_stall_cnt
    );

    modport master (
        output i_id_valid, i_id_src1, i_id_src2, i_id_two_src, i_id_dest,
               i_id_wb_en, i_id_mem_read, i_branch_taken,
        input  o_stall, o_sel_src1, o_sel_src2, o_stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Hazard and forwarding controller: EX/MEM/WB destination scoreboard, EX operand mux selects,
// load-use (or plain RAW without forwarding) stall and a saturating stall counter.
module fwd_hazard_ctrl #(
    parameter int REG_ADDR_LEN = 4,
    parameter bit FWD_EN       = 1'b1,
    parameter int CNT_LEN      = 16
) (
    input  logic               clk,
    input  logic               rst,
    fwd_hazard_ctrl_if.slave   bus
);
    typedef struct packed {
        logic                    valid;
        logic                    wb_en;
        logic                    mem_read;
        logic [REG_ADDR_LEN-1:0] dest;
    } rec_t;

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_WB  = 2'd2;

    rec_t               r_ex;
    rec_t               r_mem;
    rec_t               r_wb;
    logic [1:0]         r_sel_src1;
    logic [1:0]         r_sel_src2;
    logic [CNT_LEN-1:0] r_stall_cnt;

    logic       w_ex_m1;
    logic       w_ex_m2;
    logic       w_mem_m1;
    logic       w_mem_m2;
    logic       w_stall;
    logic       w_advance;
    logic [1:0] w_sel1;
    logic [1:0] w_sel2;
    rec_t       w_id_rec;

    function automatic logic rec_match(input rec_t r, input logic [REG_ADDR_LEN-1:0] src);
        return r.valid & r.wb_en & (r.dest == src);
    endfunction

    // The nearest producer wins: EX now will sit in MEM when this instruction reaches EX.
    function automatic logic [1:0] pick_sel(input logic ex_m, input logic mem_m);
        logic [1:0] sel;
        sel = SEL_RF;
        if (!FWD_EN) begin
            sel = SEL_RF;
        end else if (ex_m) begin
            sel = SEL_MEM;
        end else if (mem_m) begin
            sel = SEL_WB;
        end else begin
            sel = SEL_RF;
        end
        return sel;
    endfunction

    assign w_ex_m1  = rec_match(r_ex, bus.i_id_src1);
    assign w_ex_m2  = bus.i_id_two_src & rec_match(r_ex, bus.i_id_src2);
    assign w_mem_m1 = rec_match(r_mem, bus.i_id_src1);
    assign w_mem_m2 = bus.i_id_two_src & rec_match(r_mem, bus.i_id_src2);

    // Stall decision; a flush or an empty ID slot never stalls.
    always_comb begin
        w_stall = 1'b0;
        if (bus.i_branch_taken || !bus.i_id_valid) begin
            w_stall = 1'b0;
        end else if (FWD_EN) begin
            w_stall = r_ex.mem_read & (w_ex_m1 | w_ex_m2);
        end else begin
            w_stall = w_ex_m1 | w_ex_m2 | w_mem_m1 | w_mem_m2;
        end
    end

    assign w_advance = bus.i_id_valid & ~w_stall & ~bus.i_branch_taken;
    assign w_sel1    = pick_sel(w_ex_m1, w_mem_m1);
    assign w_sel2    = pick_sel(w_ex_m2, w_mem_m2);
    assign w_id_rec  = '{valid: 1'b1, wb_en: bus.i_id_wb_en, mem_read: bus.i_id_mem_read,
                         dest: bus.i_id_dest};

    // Scoreboard shift, select registration and stall counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex        <= '0;
            r_mem       <= '0;
            r_wb        <= '0;
            r_sel_src1  <= SEL_RF;
            r_sel_src2  <= SEL_RF;
            r_stall_cnt <= {CNT_LEN{1'b0}};
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            if (w_advance) begin
                r_ex       <= w_id_rec;
                r_sel_src1 <= w_sel1;
                r_sel_src2 <= w_sel2;
            end else begin
                r_ex       <= '0;
                r_sel_src1 <= SEL_RF;
                r_sel_src2 <= SEL_RF;
            end
            if (w_stall && (r_stall_cnt != {CNT_LEN{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + {{(CNT_LEN-1){1'b0}}, 1'b1};
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
        end
    end

    assign bus.o_stall     = w_stall;
    assign bus.o_sel_src1  = r_sel_src1;
    assign bus.o_sel_src2  = r_sel_src2;
    assign bus.o_stall_cnt = r_stall_cnt;
endmodule
